// File: rtl/core_mdu_pkg.sv
// core_mdu shared definitions: M-extension funct3 codes,
// FSM states and operand signedness helpers.
package core_mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_t;

  function automatic logic rs1_signed(input logic [2:0] f3);
    return f3 inside {MDU_MUL, MDU_MULH, MDU_MULHSU,
                      MDU_DIV, MDU_REM};
  endfunction

  function automatic logic rs2_signed(input logic [2:0] f3);
    return f3 inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
  endfunction

endpackage

// File: rtl/core_mdu_div.sv
// Iterative restoring divider on unsigned magnitudes,
// one quotient bit per clock, 32 or XLEN iterations.
module core_mdu_div
  import core_mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_w,
  input  logic [XLEN-1:0] i_dvd,
  input  logic [XLEN-1:0] i_dvs,
  output logic            o_done,
  output logic [XLEN-1:0] o_quo,
  output logic [XLEN-1:0] o_rem
);

  localparam int CW = $clog2(XLEN + 1);

  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_q;
  logic [XLEN-1:0] r_r;
  logic [XLEN-1:0] r_d;
  logic [XLEN:0]   w_sh;
  logic [XLEN:0]   w_diff;
  logic            w_ge;

  assign w_sh   = {r_r, r_q[XLEN-1]};
  assign w_diff = w_sh - {1'b0, r_d};
  assign w_ge   = ~w_diff[XLEN];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_d   <= '0;
    end else if (i_start) begin
      // W dividends are pre-shifted so their MSB leads
      r_q   <= i_w ? (i_dvd << (XLEN - 32)) : i_dvd;
      r_r   <= '0;
      r_d   <= i_dvs;
      r_cnt <= i_w ? CW'(32) : CW'(XLEN);
    end else if (r_cnt != '0) begin
      r_r   <= w_ge ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0];
      r_q   <= {r_q[XLEN-2:0], w_ge};
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_done = (r_cnt == '0);
  assign o_quo  = r_q;
  assign o_rem  = r_r;

endmodule

// File: rtl/core_mdu.sv
// RV64IM multiply/divide unit: shift-add multiplier,
// restoring divider, sign fix-up and valid/ready handshakes.
module core_mdu
  import core_mdu_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int RFIDX_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_funct3,
  input  logic                   in_op_w,
  input  logic [XLEN-1:0]        in_oprd1,
  input  logic [XLEN-1:0]        in_oprd2,
  input  logic [RFIDX_WIDTH-1:0] in_rd_idx,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_result,
  output logic [RFIDX_WIDTH-1:0] out_rd_idx,
  output logic                   busy
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] W_MASK = XLEN'(32'hFFFF_FFFF);

  function automatic logic [XLEN-1:0] fmt(
    input logic [XLEN-1:0] v, input logic w);
    return w ? XLEN'($signed(v[31:0])) : v;
  endfunction

  mdu_state_t r_state, w_next;

  logic [2:0]             r_f3;
  logic                   r_w;
  logic                   r_neg;
  logic                   r_spec;
  logic [RFIDX_WIDTH-1:0] r_rd;
  logic [CW-1:0]          r_cnt;
  logic [2*XLEN-1:0]      r_acc;
  logic [2*XLEN-1:0]      r_mcand;
  logic [XLEN-1:0]        r_mplr;
  logic [XLEN-1:0]        r_res;

  logic              w_accept;
  logic [XLEN-1:0]   w_nmask, w_a, w_b, w_ma, w_mb, w_min;
  logic              w_sa, w_sb, w_neg, w_is_div, w_is_rem;
  logic              w_div0, w_ovf, w_spec;
  logic [XLEN-1:0]   w_spec_res;
  logic              w_div_done, w_calc_end;
  logic [XLEN-1:0]   w_dq, w_dr, w_quo, w_rem, w_hi, w_fix;
  logic [2*XLEN-1:0] w_prod;

  assign in_ready  = (r_state == S_IDLE) & ~flush;
  assign out_valid = (r_state == S_DONE) & ~flush;
  assign busy      = (r_state != S_IDLE);
  assign w_accept  = in_valid & in_ready;

  assign w_nmask  = in_op_w ? W_MASK : '1;
  assign w_a      = in_oprd1 & w_nmask;
  assign w_b      = in_oprd2 & w_nmask;
  assign w_sa     = rs1_signed(in_funct3) &
                    (in_op_w ? in_oprd1[31] : in_oprd1[XLEN-1]);
  assign w_sb     = rs2_signed(in_funct3) &
                    (in_op_w ? in_oprd2[31] : in_oprd2[XLEN-1]);
  assign w_ma     = w_sa ? ((-w_a) & w_nmask) : w_a;
  assign w_mb     = w_sb ? ((-w_b) & w_nmask) : w_b;
  assign w_is_div = in_funct3 inside {MDU_DIV, MDU_DIVU,
                                      MDU_REM, MDU_REMU};
  assign w_is_rem = in_funct3 inside {MDU_REM, MDU_REMU};
  assign w_neg    = w_is_rem ? w_sa : (w_sa ^ w_sb);

  // most-negative N-bit value is the top bit of the mask
  assign w_min  = w_nmask ^ (w_nmask >> 1);
  assign w_div0 = (w_b == '0);
  assign w_ovf  = (in_funct3 inside {MDU_DIV, MDU_REM}) &
                  (w_a == w_min) & (w_b == w_nmask);
  assign w_spec = w_is_div & (w_div0 | w_ovf);
  assign w_spec_res = w_div0 ? (w_is_rem ? w_a : w_nmask)
                             : (w_is_rem ? '0 : w_a);

  core_mdu_div #(.XLEN(XLEN)) u_div (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_accept & w_is_div & ~w_spec),
    .i_w     (in_op_w),
    .i_dvd   (w_ma),
    .i_dvs   (w_mb),
    .o_done  (w_div_done),
    .o_quo   (w_dq),
    .o_rem   (w_dr)
  );

  assign w_calc_end = (r_cnt == '0) & (~r_f3[2] | w_div_done);
  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quo  = r_neg ? -w_dq : w_dq;
  assign w_rem  = r_neg ? -w_dr : w_dr;
  assign w_hi   = r_w ? XLEN'(w_prod[63:32])
                      : w_prod[2*XLEN-1:XLEN];

  always_comb begin
    w_fix = '0;
    unique case (1'b1)
      (r_f3 == MDU_MUL):
        w_fix = fmt(w_prod[XLEN-1:0], r_w);
      (r_f3 inside {MDU_MULH, MDU_MULHSU, MDU_MULHU}):
        w_fix = fmt(w_hi, r_w);
      (r_f3 inside {MDU_REM, MDU_REMU}):
        w_fix = fmt(w_rem, r_w);
      default:
        w_fix = fmt(w_quo, r_w);
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_CALC;
      // special cases resolve in a single CALC edge
      S_CALC: begin
        if (r_spec)          w_next = S_DONE;
        else if (w_calc_end) w_next = S_FIX;
      end
      S_FIX:  w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_f3    <= '0;
      r_w     <= 1'b0;
      r_neg   <= 1'b0;
      r_spec  <= 1'b0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_f3    <= in_funct3;
        r_w     <= in_op_w;
        r_neg   <= w_neg;
        r_spec  <= w_spec;
        r_rd    <= in_rd_idx;
        r_cnt   <= w_spec ? '0
                 : (in_op_w ? CW'(32) : CW'(XLEN));
        r_acc   <= '0;
        r_mcand <= {{XLEN{1'b0}}, w_ma};
        r_mplr  <= w_mb;
        if (w_spec) r_res <= fmt(w_spec_res, in_op_w);
      end else if (r_state == S_CALC && r_cnt != '0) begin
        r_cnt   <= r_cnt - CW'(1);
        if (r_mplr[0]) r_acc <= r_acc + r_mcand;
        r_mcand <= r_mcand << 1;
        r_mplr  <= r_mplr >> 1;
      end else if (r_state == S_FIX) begin
        r_res <= w_fix;
      end
    end
  end

  assign out_result = r_res;
  assign out_rd_idx = r_rd;

endmodule

// File: tb/tb_core_mdu.sv
// Scoreboard bench for core_mdu: directed ops with expected
// results and latencies, backpressure, flush and reset cases.
module tb_core_mdu;
  import core_mdu_pkg::*;

  localparam int XLEN = 64;
  localparam int RW   = 5;
  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [XLEN-1:0] MINV = 64'h8000_0000_0000_0000;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, in_op_w;
  logic            out_valid, out_ready, busy;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_oprd1, in_oprd2, out_result;
  logic [RW-1:0]   in_rd_idx, out_rd_idx;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string           nm;
    logic [XLEN-1:0] res;
    logic [RW-1:0]   rd;
    int              cyc;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;

  core_mdu #(.XLEN(XLEN), .RFIDX_WIDTH(RW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_funct3  (in_funct3),
    .in_op_w    (in_op_w),
    .in_oprd1   (in_oprd1),
    .in_oprd2   (in_oprd2),
    .in_rd_idx  (in_rd_idx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd_idx (out_rd_idx),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got %h want none",
                 out_result);
      end else begin
        m_e = sb.pop_front();
        check({m_e.nm, "_res"}, out_result, m_e.res);
        check({m_e.nm, "_rd"}, XLEN'(out_rd_idx),
              XLEN'(m_e.rd));
        if (m_e.cyc >= 0)
          check({m_e.nm, "_lat"}, XLEN'(cyc), XLEN'(m_e.cyc));
      end
    end
  end

  task automatic issue(input string nm, input logic [2:0] f3,
                       input logic w,
                       input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b,
                       input logic [RW-1:0] rd,
                       input logic [XLEN-1:0] exp,
                       input int lat, input bit push);
    int k = 0;
    @(posedge clk); #1;
    while (!in_ready && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_accept: got in_ready=0 want 1", nm);
      return;
    end
    in_valid  = 1'b1;
    in_funct3 = f3;
    in_op_w   = w;
    in_oprd1  = a;
    in_oprd2  = b;
    in_rd_idx = rd;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push)
      sb.push_back('{nm, exp, rd, (lat < 0) ? -1 : cyc + lat});
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 400) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int k;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_op_w = 1'b0; in_funct3 = '0; out_ready = 1'b1;
    in_oprd1 = '0; in_oprd2 = '0; in_rd_idx = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", XLEN'(out_valid), 0);
    check("rst_busy", XLEN'(busy), 0);
    check("rst_in_ready", XLEN'(in_ready), 1);
    check("rst_result", out_result, 0);
    check("rst_rd", XLEN'(out_rd_idx), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    issue("mul_7x-3", MDU_MUL, 0, 7, 64'hFFFF_FFFF_FFFF_FFFD,
          1, 64'hFFFF_FFFF_FFFF_FFEB, 66, 1);
    ok = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (!busy || in_ready) ok = 1'b0;
    end
    check("mul_busy_hold", XLEN'(ok), 1);

    issue("mulhu", MDU_MULHU, 0, ONES, 2, 2, 1, 66, 1);
    issue("mulhsu", MDU_MULHSU, 0, ONES, ONES, 3, ONES, 66, 1);
    issue("mulh", MDU_MULH, 0, ONES, ONES, 4, 0, 66, 1);

    issue("div_by0", MDU_DIV, 0, 5, 0, 5, ONES, 1, 1);
    issue("rem_by0", MDU_REM, 0, 5, 0, 6, 5, 1, 1);
    issue("div_ovf", MDU_DIV, 0, MINV, ONES, 7, MINV, 1, 1);
    issue("rem_ovf", MDU_REM, 0, MINV, ONES, 8, 0, 1, 1);
    issue("divu_by0", MDU_DIVU, 0, 5, 0, 10, ONES, 1, 1);
    issue("remu_by0", MDU_REMU, 0, 5, 0, 11, 5, 1, 1);

    issue("divw", MDU_DIV, 1, 64'hFFFF_FFFF_FFFF_FFF9, 2, 12,
          64'hFFFF_FFFF_FFFF_FFFD, 34, 1);
    issue("remw", MDU_REM, 1, 64'hFFFF_FFFF_FFFF_FFF9, 2, 13,
          ONES, 34, 1);
    issue("divuw", MDU_DIVU, 1, 64'h8000_0000, 1, 14,
          64'hFFFF_FFFF_8000_0000, 34, 1);
    issue("mulw_a", MDU_MUL, 1, 64'h7FFF_FFFF, 2, 15,
          64'hFFFF_FFFF_FFFF_FFFE, 34, 1);
    issue("mulw_b", MDU_MUL, 1, 64'hFFFF_FFFF_FFFF_FFFD, 5, 16,
          64'hFFFF_FFFF_FFFF_FFF1, 34, 1);
    issue("divw_ovf", MDU_DIV, 1, 64'h8000_0000, ONES, 18,
          64'hFFFF_FFFF_8000_0000, 1, 1);
    issue("remuw_by0", MDU_REMU, 1, 7, 0, 19, 7, 1, 1);

    issue("div_neg", MDU_DIV, 0, 100, 64'hFFFF_FFFF_FFFF_FFF9,
          20, 64'hFFFF_FFFF_FFFF_FFF2, 66, 1);
    issue("rem_neg", MDU_REM, 0, 64'hFFFF_FFFF_FFFF_FF9C, 7,
          21, 64'hFFFF_FFFF_FFFF_FFFE, 66, 1);
    issue("divu_big", MDU_DIVU, 0, ONES, 16, 22,
          64'h0FFF_FFFF_FFFF_FFFF, 66, 1);
    issue("mul_x0", MDU_MUL, 0, 6, 7, 0, 42, 66, 1);
    drain();

    @(posedge clk); #1;
    out_ready = 1'b0;
    issue("bp", MDU_DIVU, 0, 100, 7, 9, 14, -1, 1);
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("bp_valid", XLEN'(out_valid), 1);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!out_valid || in_ready || out_result != 14 ||
          out_rd_idx != 9) ok = 1'b0;
    end
    check("bp_stable", XLEN'(ok), 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_busy", XLEN'(busy), 0);
    check("bp_idle_ready", XLEN'(in_ready), 1);
    drain();

    issue("flush_div", MDU_DIV, 0, 1000, 3, 23, 0, 66, 0);
    repeat (19) @(posedge clk);
    #1;
    flush = 1'b1;
    in_valid = 1'b1;
    in_funct3 = MDU_MUL;
    in_oprd1 = 2;
    in_oprd2 = 2;
    @(negedge clk);
    check("flush_out_valid", XLEN'(out_valid), 0);
    check("flush_in_ready", XLEN'(in_ready), 0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_idle", XLEN'(busy), 0);

    issue("rst_mul", MDU_MUL, 0, 3, 3, 17, 0, 66, 0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b1;
    in_oprd1 = 5;
    in_oprd2 = 5;
    in_rd_idx = 24;
    @(posedge clk);
    @(negedge clk);
    check("mrst_out_valid", XLEN'(out_valid), 0);
    check("mrst_busy", XLEN'(busy), 0);
    check("mrst_in_ready", XLEN'(in_ready), 1);
    check("mrst_result", out_result, 0);
    check("mrst_rd", XLEN'(out_rd_idx), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("mrst_not_accepted", XLEN'(busy), 0);

    issue("post_rst", MDU_MUL, 0, 6, 7, 3, 42, 66, 1);
    drain();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
